// File: rtl/mult_pkg.sv
// Shared types and per-partial-product tables for the sequential 8x8 multiplier.
package mult_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int PP_NUM = 4;

  // Bit k set: partial product k takes the high nibble of that operand.
  localparam logic [PP_NUM-1:0] PP_A_HI = 4'b1100;
  localparam logic [PP_NUM-1:0] PP_B_HI = 4'b1010;
  localparam logic [PP_NUM-1:0][3:0] PP_SHIFT = {4'd8, 4'd4, 4'd4, 4'd0};

  localparam logic SEL_EXACT  = 1'b0;
  localparam logic SEL_APPROX = 1'b1;

  function automatic logic [3:0] nib(input logic [7:0] x, input logic hi);
    return hi ? x[7:4] : x[3:0];
  endfunction

endpackage

// File: rtl/mult_8x8_seq_sched.sv
// Computes one 8x8 unsigned product by issuing four 4x4 partials to a shared
// external core and accumulating the tagged results.
module mult_8x8_seq_sched
  import mult_pkg::*;
#(
  parameter int              MUL_LAT     = 0,
  parameter logic [3:0]      APPROX_MASK = 4'b1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic [3:0]  mul_a,
  output logic [3:0]  mul_b,
  output logic        mul_sel,
  input  logic [7:0]  mul_r,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_r,
  output logic        busy
);

  if (MUL_LAT < 0 || MUL_LAT > 3) begin : g_bad_lat
    $error("MUL_LAT must be in 0..3");
  end

  localparam logic [1:0] PP_LAST = 2'(PP_NUM - 1);

  state_t      state;
  logic [7:0]  a_q, b_q;
  logic [15:0] acc;
  logic        iss_vld;
  logic [1:0]  iss_idx, nxt_idx;
  logic        fin;
  logic        accept;

  // Tag line: stage 0 is the issue currently on mul_a/mul_b, stage MUL_LAT
  // lines up with the matching mul_r.
  logic [MUL_LAT:0]      vld_pipe;
  logic [MUL_LAT:0][1:0] idx_pipe;

  assign in_ready = (state == IDLE) || (state == DONE && out_ready);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;
  assign nxt_idx  = iss_idx + 2'd1;

  assign vld_pipe[0] = iss_vld;
  assign idx_pipe[0] = iss_idx;

  for (genvar i = 1; i <= MUL_LAT; i++) begin : g_tag
    logic       v_q;
    logic [1:0] k_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        k_q <= 2'd0;
      end else begin
        v_q <= vld_pipe[i-1];
        k_q <= idx_pipe[i-1];
      end
    end
    assign vld_pipe[i] = v_q;
    assign idx_pipe[i] = k_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= 8'd0;
      b_q       <= 8'd0;
      acc       <= 16'd0;
      iss_vld   <= 1'b0;
      iss_idx   <= 2'd0;
      fin       <= 1'b0;
      mul_a     <= 4'd0;
      mul_b     <= 4'd0;
      mul_sel   <= SEL_EXACT;
      out_valid <= 1'b0;
      out_r     <= 16'd0;
    end else begin
      case (state)
        RUN: begin
          if (iss_vld) begin
            if (iss_idx == PP_LAST) begin
              iss_vld <= 1'b0;
              mul_a   <= 4'd0;
              mul_b   <= 4'd0;
              mul_sel <= SEL_EXACT;
            end else begin
              iss_idx <= nxt_idx;
              mul_a   <= nib(a_q, PP_A_HI[nxt_idx]);
              mul_b   <= nib(b_q, PP_B_HI[nxt_idx]);
              mul_sel <= APPROX_MASK[nxt_idx];
            end
          end
          if (vld_pipe[MUL_LAT]) begin
            acc <= acc + (16'(mul_r) << PP_SHIFT[idx_pipe[MUL_LAT]]);
            if (idx_pipe[MUL_LAT] == PP_LAST) fin <= 1'b1;
          end
          // One settle cycle after the last partial gives the 5+MUL_LAT latency.
          if (fin) begin
            fin       <= 1'b0;
            state     <= DONE;
            out_valid <= 1'b1;
            out_r     <= acc;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
      if (accept) begin
        state   <= RUN;
        a_q     <= in_a;
        b_q     <= in_b;
        acc     <= 16'd0;
        iss_vld <= 1'b1;
        iss_idx <= 2'd0;
        mul_a   <= in_a[3:0];
        mul_b   <= in_b[3:0];
        mul_sel <= APPROX_MASK[0];
      end
    end
  end

endmodule

// File: tb/tb_mult_8x8_seq_sched.sv
// Bench: five scheduler instances (MUL_LAT 0..3 exact, MUL_LAT 2 with k3 approx),
// each paired with a 4x4 core model, checked against an arithmetic reference.
module tb_mult_8x8_seq_sched;

  localparam int NI = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] in_a = 8'd0, in_b = 8'd0;
  logic [NI-1:0] in_valid = '0, out_ready = '1;
  logic [NI-1:0] in_ready, out_valid, busy, mul_sel;
  logic [NI-1:0][3:0]  mul_a, mul_b;
  logic [NI-1:0][7:0]  mul_r;
  logic [NI-1:0][15:0] out_r;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  function automatic int lat_of(input int j);
    return (j == 4) ? 2 : j;
  endfunction

  function automatic logic [3:0] mask_of(input int j);
    return (j == 4) ? 4'b1000 : 4'b0000;
  endfunction

  // Approximate core variant: exact product with LSB forced high.
  function automatic int approx(input int a, input int b);
    return (a * b) | 1;
  endfunction

  // Reference: exact a*b, corrected by the approx-vs-exact delta of each
  // approximate partial at its weight, taken modulo 2^16.
  function automatic logic [15:0] ref_prod(input int a, input int b, input logic [3:0] mask);
    int r, ah, bh, sh;
    r = a * b;
    for (int k = 0; k < 4; k++) begin
      if (mask[k]) begin
        ah = (k >= 2) ? (a / 16) : (a % 16);
        bh = (k % 2 == 1) ? (b / 16) : (b % 16);
        sh = (k == 0) ? 0 : (k == 3) ? 8 : 4;
        r  = r + ((approx(ah, bh) - ah * bh) << sh);
      end
    end
    return r[15:0];
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int         LAT = (g == 4) ? 2 : g;
    localparam logic [3:0] MSK = (g == 4) ? 4'b1000 : 4'b0000;
    logic [7:0] prod;
    logic [7:0] dl [0:3];

    assign prod = mul_sel[g] ? 8'(approx(int'(mul_a[g]), int'(mul_b[g])))
                             : 8'(int'(mul_a[g]) * int'(mul_b[g]));
    always @(posedge clk) begin
      dl[0] <= prod;
      for (int i = 1; i < 4; i++) dl[i] <= dl[i-1];
    end
    if (LAT == 0) begin : g_comb
      assign mul_r[g] = prod;
    end else begin : g_reg
      assign mul_r[g] = dl[LAT-1];
    end

    mult_8x8_seq_sched #(.MUL_LAT(LAT), .APPROX_MASK(MSK)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .in_a(in_a), .in_b(in_b),
      .mul_a(mul_a[g]), .mul_b(mul_b[g]), .mul_sel(mul_sel[g]), .mul_r(mul_r[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out_r(out_r[g]),
      .busy(busy[g])
    );
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called #1 after the accepting edge; waits for out_valid and checks
  // issue-select sequence, latency and result.
  task automatic finish_op(input int j, input logic [15:0] exp, input string tag);
    int c = 0;
    logic [3:0] sels = 4'd0;
    in_a = ~in_a;
    in_b = ~in_b;
    while (!out_valid[j] && c < 20) begin
      if (c < 4) sels[c] = mul_sel[j];
      step();
      c++;
    end
    chk({tag, "_lat"}, c, 5 + lat_of(j));
    chk({tag, "_sel"}, {28'd0, sels}, {28'd0, mask_of(j)});
    chk({tag, "_r"}, {16'd0, out_r[j]}, {16'd0, exp});
  endtask

  task automatic run_op(input int j, input logic [7:0] a, input logic [7:0] b, input string tag);
    int w = 0;
    while (!in_ready[j] && w < 20) begin
      step();
      w++;
    end
    chk({tag, "_rdy"}, {31'd0, in_ready[j]}, 32'd1);
    in_a = a;
    in_b = b;
    in_valid[j] = 1'b1;
    step();
    in_valid[j] = 1'b0;
    finish_op(j, ref_prod(a, b, mask_of(j)), tag);
  endtask

  initial begin
    logic [15:0] held;
    logic [7:0] ra, rb;

    step();
    step();
    rst = 1'b0;
    for (int j = 0; j < NI; j++) begin
      chk("rst_in_ready", {31'd0, in_ready[j]}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid[j]}, 32'd0);
      chk("rst_busy", {31'd0, busy[j]}, 32'd0);
      chk("rst_out_r", {16'd0, out_r[j]}, 32'd0);
      chk("rst_mul", {23'd0, mul_a[j], mul_b[j], mul_sel[j]}, 32'd0);
    end

    run_op(0, 8'd255, 8'd255, "max_l0");
    chk("max_l0_val", {16'd0, out_r[0]}, 32'd65025);
    step();
    run_op(2, 8'h3C, 8'hA5, "l2");
    chk("l2_val", {16'd0, out_r[2]}, 32'd9900);
    step();
    run_op(4, 8'hF7, 8'hE3, "approx");
    chk("approx_val", {16'd0, out_r[4]}, 32'd56325);
    step();

    // Backpressure then back-to-back accept on the handshake edge.
    out_ready[0] = 1'b0;
    run_op(0, 8'd123, 8'd45, "bp");
    held = out_r[0];
    in_valid[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_a = 8'($urandom);
      in_b = 8'($urandom);
      step();
      chk("bp_hold_r", {16'd0, out_r[0]}, {16'd0, held});
      chk("bp_hold_v", {30'd0, out_valid[0], in_ready[0]}, 32'd2);
    end
    in_a = 8'd200;
    in_b = 8'd77;
    out_ready[0] = 1'b1;
    step();
    in_valid[0] = 1'b0;
    chk("b2b_accept", {30'd0, out_valid[0], busy[0]}, 32'd1);
    finish_op(0, 16'd15400, "b2b");
    step();

    // Reset two cycles into RUN, then a clean op.
    in_a = 8'hFF;
    in_b = 8'hFF;
    in_valid[2] = 1'b1;
    step();
    in_valid[2] = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_outs", {10'd0, out_r[2], in_ready[2], out_valid[2], busy[2], mul_a[2], mul_sel[2]},
        {10'd0, 16'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0});
    run_op(2, 8'd16, 8'd16, "post_rst");
    chk("post_rst_val", {16'd0, out_r[2]}, 32'd256);
    step();

    for (int j = 0; j < NI; j++) begin
      for (int n = 0; n < 300; n++) begin
        ra = 8'($urandom);
        rb = 8'($urandom);
        run_op(j, ra, rb, "rand");
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
